sumador_serial: RTL and testbench

- Bit-serial N-bit adder built around the team's gate-level half-adder cell (S = A xor B, C = A and B).
- Two half-adder instances plus an OR form one full-adder slice that processes one operand bit per clock, LSB first.
- A carry flip-flop links successive bits; the sum is accumulated in a shift register.
- Upstream it takes parallel operands with a start pulse; downstream it presents a parallel sum, carry-out and a one-cycle done pulse.

---
 rtl/sumador_serial_if.sv | 23 ++
 rtl/sumador_serial.sv | 125 ++++++++++++
 tb/tb_sumador_serial.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sumador_serial_if.sv
// Handshake bundle for the bit-serial adder.
// The master drives operands and start; the slave returns the result.
interface sumador_serial_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         busy;
    logic         done;
    logic [N-1:0] suma;
    logic         acarreo;

    modport master (
        output start, a, b,
        input  busy, done, suma, acarreo
    );

    modport slave (
        input  start, a, b,
        output busy, done, suma, acarreo
    );
endinterface

// File: rtl/sumador_serial.sv
// Bit-serial N-bit adder: one full-adder slice built from two
// half-adder cells, processing one operand bit per clock, LSB first.
module medio_sumador (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);
    xor g_s (s_o, a_i, b_i);
    and g_c (c_o, a_i, b_i);
endmodule

module sumador_serial #(
    parameter int N = 8
) (
    input  logic            clk,
    input  logic            rst,
    sumador_serial_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        SUMA,
        FIN
    } estado_t;

    estado_t       estado_q, estado_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  sum_q, sum_d;
    logic          c_q, c_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  suma_q, suma_d;
    logic          acarreo_q, acarreo_d;

    logic s1, c1, s_bit, c2, c_nuevo;

    medio_sumador u_ha0 (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .s_o (s1),
        .c_o (c1)
    );

    medio_sumador u_ha1 (
        .a_i (s1),
        .b_i (c_q),
        .s_o (s_bit),
        .c_o (c2)
    );

    assign c_nuevo = c1 | c2;

    // Next state: load on start, shift one bit per cycle, publish at the end
    always_comb begin
        estado_d  = estado_q;
        a_d       = a_q;
        b_d       = b_q;
        sum_d     = sum_q;
        c_d       = c_q;
        cnt_d     = cnt_q;
        suma_d    = suma_q;
        acarreo_d = acarreo_q;
        unique case (estado_q)
            IDLE: begin
                if (bus.start) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    c_d      = 1'b0;
                    cnt_d    = '0;
                    estado_d = SUMA;
                end
            end
            SUMA: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                sum_d = {s_bit, sum_q[N-1:1]};
                c_d   = c_nuevo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ULTIMO) begin
                    suma_d    = {s_bit, sum_q[N-1:1]};
                    acarreo_d = c_nuevo;
                    cnt_d     = '0;
                    estado_d  = FIN;
                end
            end
            FIN: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q  <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            c_q       <= 1'b0;
            cnt_q     <= '0;
            suma_q    <= '0;
            acarreo_q <= 1'b0;
        end else begin
            estado_q  <= estado_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sum_q     <= sum_d;
            c_q       <= c_d;
            cnt_q     <= cnt_d;
            suma_q    <= suma_d;
            acarreo_q <= acarreo_d;
        end
    end

    assign bus.busy    = (estado_q != IDLE);
    assign bus.done    = (estado_q == FIN);
    assign bus.suma    = suma_q;
    assign bus.acarreo = acarreo_q;
endmodule

// File: tb/tb_sumador_serial.sv
// Testbench for the bit-serial adder: directed cases plus a random
// sweep checked against plain a+b arithmetic.
module tb_sumador_serial;
    localparam int N = 8;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_tot;
    int   n_done;

    sumador_serial_if #(.N(N)) bus ();

    sumador_serial #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every cycle in which done is seen high
    always @(posedge clk) begin
        if (bus.done === 1'b1) n_done++;
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One complete addition; optional stray start pulses mid-run and in FIN
    task automatic op(input logic [N-1:0] x, input logic [N-1:0] y,
                      input int pulse_at, input bit fin_pulse);
        logic [N:0]   ref_v;
        logic [N-1:0] prev;
        int           lat;
        int           d0;
        bit           held;
        ref_v = {1'b0, x} + {1'b0, y};
        prev  = bus.suma;
        held  = 1'b1;
        @(negedge clk);
        bus.a     = x;
        bus.b     = y;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        d0        = n_done;
        bus.start = 1'b0;
        bus.a     = N'($urandom);
        bus.b     = N'($urandom);
        lat       = 1;
        while (bus.done !== 1'b1 && lat < 4 * N) begin
            if (bus.suma !== prev || bus.busy !== 1'b1) held = 1'b0;
            if (lat == pulse_at) begin
                bus.start = 1'b1;
                bus.a     = '1;
                bus.b     = '1;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            lat++;
        end
        check("latency", lat, N + 1);
        check("suma", bus.suma, ref_v[N-1:0]);
        check("acarreo", bus.acarreo, ref_v[N]);
        check("no_partial", held, 1);
        check("busy_fin", bus.busy, 1);
        if (fin_pulse) begin
            bus.start = 1'b1;
            bus.a     = '1;
            bus.b     = '1;
        end
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("done_clr", bus.done, 0);
        check("busy_clr", bus.busy, 0);
        check("one_done", n_done - d0, 1);
    endtask

    initial begin
        int d0;
        n_pass    = 0;
        n_tot     = 0;
        n_done    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_suma", bus.suma, 0);
        check("rst_acarreo", bus.acarreo, 0);

        // rst wins over start in the same cycle
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
        @(posedge clk);
        #1;
        check("rst_prio", bus.busy, 0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;

        op(8'h5A, 8'h3C, -1, 1'b0);
        op(8'hFF, 8'h01, -1, 1'b0);
        op(8'hFF, 8'hFF, -1, 1'b0);
        op(8'h00, 8'h00, -1, 1'b0);
        op(8'h12, 8'h34, 3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("fin_ignored", bus.busy, 0);

        // Reset in the middle of an addition
        d0 = n_done;
        @(negedge clk);
        bus.a     = 8'h80;
        bus.b     = 8'h80;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_suma", bus.suma, 0);
        check("mid_rst_acarreo", bus.acarreo, 0);
        repeat (N + 3) @(posedge clk);
        #1;
        check("mid_rst_nodone", n_done - d0, 0);
        op(8'h80, 8'h80, -1, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            op(N'($urandom), N'($urandom), -1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
